// File: rtl/pulse_train_gen_if.sv
// ---------------------------------------------------------------------------
// pulse_train_gen_if
// Purpose : bundles the control handshake, run-time configuration and
//           observation outputs of pulse_train_gen.
// Signals : start, stop        - run request / abort request
//           mode               - 0 continuous, 1 burst
//           period, width      - cycles per period / high cycles per period
//           burst_len          - pulses per burst
//           pulse, busy, done  - waveform, running flag, burst-complete strobe
//           clk_count          - position within the current period
//           pulse_count        - pulses emitted in the current or last run
// Modports: master (controller side), slave (generator side)
// ---------------------------------------------------------------------------
interface pulse_train_gen_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic             mode;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] burst_len;
    logic             pulse;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] clk_count;
    logic [CNT_W-1:0] pulse_count;

    modport master (
        output start, stop, mode, period, width, burst_len,
        input  pulse, busy, done, clk_count, pulse_count
    );

    modport slave (
        input  start, stop, mode, period, width, burst_len,
        output pulse, busy, done, clk_count, pulse_count
    );
endinterface

// File: rtl/pulse_train_gen.sv
// ---------------------------------------------------------------------------
// pulse_train_gen
// Purpose : programmable pulse-train generator with run-time period and high
//           width, continuous or fixed-length burst mode, and a
//           start/stop/busy/done handshake.
// Ports   : clk  - system clock, rising edge
//           rst  - synchronous active-high reset
//           bus  - pulse_train_gen_if.slave (handshake, config, outputs)
// Params  : CNT_W - width of period/width/burst/count datapath
// Macro   : PULSE_GEN_SAT_EN - when defined, pulse_count saturates at its
//           maximum instead of wrapping. Burst termination never depends on
//           pulse_count, so pulse/busy/done are identical in both builds.
// ---------------------------------------------------------------------------
module pulse_train_gen #(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    pulse_train_gen_if.slave  bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state,      w_stateNext;
    logic             r_mode,       w_modeNext;
    logic [CNT_W-1:0] r_period,     w_periodNext;
    logic [CNT_W-1:0] r_width,      w_widthNext;
    logic [CNT_W-1:0] r_burstLen,   w_burstLenNext;
    logic [CNT_W-1:0] r_clkCount,   w_clkCountNext;
    logic [CNT_W-1:0] r_pulseCount, w_pulseCountNext;
    logic [CNT_W-1:0] r_burstCount, w_burstCountNext;
    logic             r_pulse,      w_pulseNext;
    logic             r_busy,       w_busyNext;
    logic             r_done,       w_doneNext;

    logic [CNT_W-1:0] w_cfgPeriod;
    logic [CNT_W-1:0] w_cfgPeriodM1;
    logic [CNT_W-1:0] w_cfgWidth;
    logic [CNT_W-1:0] w_cfgBurst;
    logic [CNT_W-1:0] w_clkCountInc;
    logic [CNT_W-1:0] w_pulseCountInc;
    logic             w_lastPhase;
    logic             w_burstEnd;

    // Clamped configuration: period of at least 2 and width in 1..P-1
    // guarantee one high and one low cycle per period; a zero burst length
    // is treated as a single pulse.
    assign w_cfgPeriod   = (bus.period < CNT_W'(2)) ? CNT_W'(2) : bus.period;
    assign w_cfgPeriodM1 = w_cfgPeriod - CNT_W'(1);
    assign w_cfgWidth    = (bus.width == '0)           ? CNT_W'(1)     :
                           (bus.width > w_cfgPeriodM1) ? w_cfgPeriodM1 :
                                                         bus.width;
    assign w_cfgBurst    = (bus.burst_len == '0) ? CNT_W'(1) : bus.burst_len;

    assign w_clkCountInc = r_clkCount + CNT_W'(1);
    assign w_lastPhase   = (r_clkCount == (r_period - CNT_W'(1)));
    assign w_burstEnd    = r_mode && w_lastPhase && (r_burstCount == r_burstLen);

`ifdef PULSE_GEN_SAT_EN
    assign w_pulseCountInc = (&r_pulseCount) ? r_pulseCount : (r_pulseCount + CNT_W'(1));
`else
    assign w_pulseCountInc = r_pulseCount + CNT_W'(1);
`endif

    // State and datapath registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_mode       <= 1'b0;
            r_period     <= CNT_W'(2);
            r_width      <= CNT_W'(1);
            r_burstLen   <= CNT_W'(1);
            r_clkCount   <= '0;
            r_pulseCount <= '0;
            r_burstCount <= '0;
            r_pulse      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_mode       <= w_modeNext;
            r_period     <= w_periodNext;
            r_width      <= w_widthNext;
            r_burstLen   <= w_burstLenNext;
            r_clkCount   <= w_clkCountNext;
            r_pulseCount <= w_pulseCountNext;
            r_burstCount <= w_burstCountNext;
            r_pulse      <= w_pulseNext;
            r_busy       <= w_busyNext;
            r_done       <= w_doneNext;
        end
    end

    // Next-state and registered-output logic. The outputs are computed one
    // cycle ahead so that pulse/busy/done come straight from flops.
    always_comb begin
        w_stateNext      = r_state;
        w_modeNext       = r_mode;
        w_periodNext     = r_period;
        w_widthNext      = r_width;
        w_burstLenNext   = r_burstLen;
        w_clkCountNext   = '0;
        w_pulseCountNext = r_pulseCount;
        w_burstCountNext = r_burstCount;
        w_pulseNext      = 1'b0;
        w_busyNext       = 1'b0;
        w_doneNext       = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                // stop beats start; the first period begins on the start edge
                // and already counts as a pulse.
                if (bus.start && !bus.stop) begin
                    w_stateNext      = ST_RUN;
                    w_modeNext       = bus.mode;
                    w_periodNext     = w_cfgPeriod;
                    w_widthNext      = w_cfgWidth;
                    w_burstLenNext   = w_cfgBurst;
                    w_pulseCountNext = CNT_W'(1);
                    w_burstCountNext = CNT_W'(1);
                    w_pulseNext      = 1'b1;
                    w_busyNext       = 1'b1;
                end
            end

            ST_RUN: begin
                if (bus.stop) begin
                    w_stateNext = ST_IDLE;
                end else if (w_burstEnd) begin
                    w_stateNext = ST_IDLE;
                    w_doneNext  = 1'b1;
                end else if (w_lastPhase) begin
                    // Wrap into a new period; width is at least 1 so the
                    // first cycle of every period is high.
                    w_busyNext       = 1'b1;
                    w_pulseNext      = 1'b1;
                    w_pulseCountNext = w_pulseCountInc;
                    w_burstCountNext = r_burstCount + CNT_W'(1);
                end else begin
                    w_busyNext     = 1'b1;
                    w_clkCountNext = w_clkCountInc;
                    w_pulseNext    = (w_clkCountInc < r_width);
                end
            end

            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    assign bus.pulse       = r_pulse;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.clk_count   = r_clkCount;
    assign bus.pulse_count = r_pulseCount;

endmodule

// File: tb/tb_pulse_train_gen.sv
// ---------------------------------------------------------------------------
// tb_pulse_train_gen
// Self-checking bench for pulse_train_gen (CNT_W = 8). A behavioural model
// tracks elapsed cycles since start and derives the expected outputs with
// plain arithmetic (position = t mod P, count = t div P + 1, burst ends at
// t = B*P). Build with PULSE_GEN_SAT_EN defined to check the saturating
// pulse_count variant.
// ---------------------------------------------------------------------------
module tb_pulse_train_gen;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pulse_train_gen_if #(.CNT_W(8)) bus ();

    pulse_train_gen #(.CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state: running flag, cycles since the start edge,
    // clamped configuration and unbounded pulse count.
    bit mRun;
    bit mDone;
    int mT;
    int mP;
    int mW;
    int mB;
    bit mMode;
    int mCount;

    initial begin
        mRun = 0; mDone = 0; mT = 0; mP = 2; mW = 1; mB = 1; mMode = 0; mCount = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            mRun = 0; mDone = 0; mT = 0; mCount = 0;
        end else if (!mRun) begin
            mDone = 0;
            if (bus.start && !bus.stop) begin
                mRun   = 1;
                mT     = 0;
                mMode  = bus.mode;
                mP     = (int'(bus.period) < 2) ? 2 : int'(bus.period);
                mW     = (bus.width == 0) ? 1 :
                         ((int'(bus.width) > mP - 1) ? mP - 1 : int'(bus.width));
                mB     = (bus.burst_len == 0) ? 1 : int'(bus.burst_len);
                mCount = 1;
            end
        end else begin
            mDone = 0;
            if (bus.stop) begin
                mRun = 0;
            end else begin
                mT = mT + 1;
                if (mMode && mT == mB * mP) begin
                    mRun  = 0;
                    mDone = 1;
                end else begin
                    mCount = mT / mP + 1;
                end
            end
        end
    end

    function automatic logic [18:0] expVec();
        int         pc;
        logic [7:0] ec;
`ifdef PULSE_GEN_SAT_EN
        pc = (mCount > 255) ? 255 : mCount;
`else
        pc = mCount % 256;
`endif
        ec = mRun ? 8'(mT % mP) : 8'd0;
        return {mRun && ((mT % mP) < mW), mRun, mDone, ec, 8'(pc)};
    endfunction

    logic [18:0] dutVec;
    assign dutVec = {bus.pulse, bus.busy, bus.done, bus.clk_count, bus.pulse_count};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset with start held: everything clears and start is not taken.
    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b1; bus.mode = 1'b1;
        bus.period = 8'd10; bus.width = 8'd3; bus.burst_len = 8'd4;
        tick();
        checks++;
        if (dutVec !== 19'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h want %h", dutVec, 19'd0);
        end
        rst = 1'b0; bus.start = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || dutVec !== expVec()) begin
            errors++;
            $display("[TB] FAIL reset_start_ignored: got %h want %h", dutVec, expVec());
        end
    endtask

    // Burst 10/3 x4: waveform, done exactly 40 cycles after start.
    task automatic test_burst();
        int doneAt = -1;
        int highs  = 0;
        bus.mode = 1'b1; bus.period = 8'd10; bus.width = 8'd3; bus.burst_len = 8'd4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i <= 45; i++) begin
            if (i > 0) tick();
            checks++;
            if (dutVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL burst_cycle%0d: got %h want %h", i, dutVec, expVec());
            end
            if (bus.pulse === 1'b1) highs++;
            if (bus.done === 1'b1 && doneAt < 0) doneAt = i;
        end
        checks++;
        if (doneAt !== 40) begin
            errors++;
            $display("[TB] FAIL burst_done_time: got %0d want 40", doneAt);
        end
        checks++;
        if (highs !== 12 || bus.pulse_count !== 8'd4) begin
            errors++;
            $display("[TB] FAIL burst_totals: highs %0d count %0d want 12 4", highs, bus.pulse_count);
        end
    endtask

    // Continuous 5/2, stop sampled 23 edges after the start edge.
    task automatic test_continuous_stop();
        bit sawDone = 0;
        bus.mode = 1'b0; bus.period = 8'd5; bus.width = 8'd2; bus.burst_len = 8'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 22; i++) begin
            tick();
            checks++;
            if (dutVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL cont_cycle%0d: got %h want %h", i, dutVec, expVec());
            end
            if (bus.done === 1'b1) sawDone = 1;
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        checks++;
        if (bus.pulse_count !== 8'd5 || bus.pulse !== 1'b0 || bus.busy !== 1'b0 || bus.clk_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL cont_stop: got %h want count 5, pulse/busy/clk 0", dutVec);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done === 1'b1) sawDone = 1;
        end
        checks++;
        if (sawDone !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cont_no_done: got done=1 want 0");
        end
    endtask

    // Clamps: period 1/width 0, width > period, burst_len 0.
    task automatic test_clamp();
        int highs;
        int doneAt;
        logic [7:0] perList [2] = '{8'd1, 8'd4};
        logic [7:0] widList [2] = '{8'd0, 8'd9};
        int         expHigh [2] = '{6, 9};
        for (int c = 0; c < 2; c++) begin
            highs = 0;
            bus.mode = 1'b0; bus.period = perList[c]; bus.width = widList[c];
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            for (int i = 0; i < 12; i++) begin
                if (i > 0) tick();
                checks++;
                if (dutVec !== expVec()) begin
                    errors++;
                    $display("[TB] FAIL clamp%0d_cycle%0d: got %h want %h", c, i, dutVec, expVec());
                end
                if (bus.pulse === 1'b1) highs++;
            end
            checks++;
            if (highs !== expHigh[c]) begin
                errors++;
                $display("[TB] FAIL clamp%0d_highs: got %0d want %0d", c, highs, expHigh[c]);
            end
            bus.stop = 1'b1;
            tick();
            bus.stop = 1'b0;
        end
        doneAt = -1;
        bus.mode = 1'b1; bus.period = 8'd3; bus.width = 8'd1; bus.burst_len = 8'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            checks++;
            if (dutVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL clamp_burst0_cycle%0d: got %h want %h", i, dutVec, expVec());
            end
            if (bus.done === 1'b1 && doneAt < 0) doneAt = i;
        end
        checks++;
        if (doneAt !== 3 || bus.pulse_count !== 8'd1) begin
            errors++;
            $display("[TB] FAIL clamp_burst0: done at %0d count %0d want 3 1", doneAt, bus.pulse_count);
        end
    endtask

    // Reset mid-burst, then start+stop together in IDLE, then a clean start.
    task automatic test_abort();
        int  budget = 0;
        bit  sawDone = 0;
        bus.mode = 1'b1; bus.period = 8'd4; bus.width = 8'd2; bus.burst_len = 8'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        while (bus.pulse_count !== 8'd3 && budget < 40) begin
            tick();
            budget++;
        end
        checks++;
        if (budget >= 40) begin
            errors++;
            $display("[TB] FAIL abort_wait: pulse_count %0d never reached 3", bus.pulse_count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (dutVec !== 19'd0) begin
            errors++;
            $display("[TB] FAIL abort_reset: got %h want %h", dutVec, 19'd0);
        end
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.done === 1'b1) sawDone = 1;
        end
        checks++;
        if (sawDone !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: got done=1 want 0");
        end
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || dutVec !== expVec()) begin
            errors++;
            $display("[TB] FAIL start_stop_idle: got %h want %h", dutVec, expVec());
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (dutVec !== {1'b1, 1'b1, 1'b0, 8'd0, 8'd1}) begin
            errors++;
            $display("[TB] FAIL abort_restart: got %h want %h", dutVec, {1'b1, 1'b1, 1'b0, 8'd0, 8'd1});
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    // Restart in the done cycle: three back-to-back 2x3 bursts.
    task automatic test_back_to_back();
        int dones = 0;
        int lastDone = -1;
        int gapErr = 0;
        bus.mode = 1'b1; bus.period = 8'd3; bus.width = 8'd1; bus.burst_len = 8'd2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i > 0) tick();
            bus.start = 1'b0;
            checks++;
            if (dutVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL b2b_cycle%0d: got %h want %h", i, dutVec, expVec());
            end
            if (bus.done === 1'b1) begin
                if (lastDone >= 0 && i - lastDone != 7) gapErr++;
                lastDone = i;
                dones++;
                if (dones < 3) bus.start = 1'b1;
            end
        end
        checks++;
        if (dones !== 3 || gapErr !== 0) begin
            errors++;
            $display("[TB] FAIL b2b_dones: got %0d dones %0d bad gaps want 3 0", dones, gapErr);
        end
    endtask

    // 300 pulses of period 2: wraps to 44 or saturates at 255.
    task automatic test_overflow();
        bus.mode = 1'b0; bus.period = 8'd2; bus.width = 8'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 598; i++) begin
            tick();
            checks++;
            if (dutVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL ovf_cycle%0d: got %h want %h", i, dutVec, expVec());
            end
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        checks++;
`ifdef PULSE_GEN_SAT_EN
        if (bus.pulse_count !== 8'd255) begin
            errors++;
            $display("[TB] FAIL ovf_count: got %0d want 255", bus.pulse_count);
        end
`else
        if (bus.pulse_count !== 8'd44) begin
            errors++;
            $display("[TB] FAIL ovf_count: got %0d want 44", bus.pulse_count);
        end
`endif
    endtask

    // Random runs with random aborts, ignored starts and config churn.
    task automatic test_random();
        for (int r = 0; r < 30; r++) begin
            bus.mode      = 1'($urandom_range(0, 1));
            bus.period    = 8'($urandom_range(0, 12));
            bus.width     = 8'($urandom_range(0, 14));
            bus.burst_len = 8'($urandom_range(0, 5));
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            for (int i = 0; i < 200 && (mRun || i == 0); i++) begin
                if (i > 0) tick();
                checks++;
                if (dutVec !== expVec()) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_cycle%0d: got %h want %h", r, i, dutVec, expVec());
                end
                bus.stop  = ($urandom_range(0, 39) == 0);
                bus.start = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 5) == 0) begin
                    bus.period = 8'($urandom);
                    bus.width  = 8'($urandom);
                    bus.mode   = 1'($urandom);
                end
            end
            bus.start = 1'b0;
            bus.stop  = 1'b1;
            tick();
            bus.stop  = 1'b0;
            checks++;
            if (dutVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL rand%0d_end: got %h want %h", r, dutVec, expVec());
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0;
        bus.period = 8'd0; bus.width = 8'd0; bus.burst_len = 8'd0;
        tick();
        tick();
        test_reset();
        test_burst();
        test_continuous_stop();
        test_clamp();
        test_abort();
        test_back_to_back();
        test_overflow();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
